// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder
// Memory-mapped machine timer that sits beside data memory on the LSU
// request bus. It holds a prescaled 64-bit mtime counter, a 64-bit mtimecmp
// compare register, a control register and a sticky interrupt-pending flag.
//
// Register window (offset = addr[7:0], word-aligned accesses only):
//   0x00 MTIME_LO  0x04 MTIME_HI (reads the HI shadow)
//   0x08 CMP_LO    0x0C CMP_HI
//   0x10 CTRL      bit0 en, bit1 ie, bits[8+PRESC_W-1:8] div
//   0x14 STATUS    bit0 irq_pending, write-1-to-clear
//
// Ports:
//   clk        core clock
//   rst        asynchronous active-low reset
//   cs, wr     request select and write strobe from the LSU
//   mask       byte enables for writes
//   addr       byte address
//   data_wr    write data
//   data_rd    combinational read data (0 when the access is not a hit)
//   timer_irq  level interrupt = irq_pending & ie
//   mtime_o    current mtime, for debug / CSR shadowing
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        timer_irq,
    output logic [63:0] mtime_o
);

    localparam logic [23:0] BASE_HI  = BASE_ADDR[31:8];
    localparam logic [7:0]  OFF_MLO  = 8'h00;
    localparam logic [7:0]  OFF_MHI  = 8'h04;
    localparam logic [7:0]  OFF_CLO  = 8'h08;
    localparam logic [7:0]  OFF_CHI  = 8'h0C;
    localparam logic [7:0]  OFF_CTRL = 8'h10;
    localparam logic [7:0]  OFF_STAT = 8'h14;

    // Replace only the byte lanes selected by be; other lanes keep old_val.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Architectural state
    logic [63:0]        mtime_r;
    logic [63:0]        cmp_r;
    logic               en_r;
    logic               ie_r;
    logic [PRESC_W-1:0] div_r;
    logic [PRESC_W-1:0] pcnt_r;
    logic [31:0]        hi_shadow_r;
    logic               pending_r;

    // Next-state values
    logic [63:0]        mtime_nxt_s;
    logic [63:0]        cmp_nxt_s;
    logic               en_nxt_s;
    logic               ie_nxt_s;
    logic [PRESC_W-1:0] div_nxt_s;
    logic [PRESC_W-1:0] pcnt_nxt_s;
    logic [31:0]        hi_shadow_nxt_s;
    logic               pending_nxt_s;

    // Decode
    logic        hit_s;
    logic        rd_hit_s;
    logic        wr_hit_s;
    logic [7:0]  off_s;
    logic        we_mlo_s;
    logic        we_mhi_s;
    logic        we_clo_s;
    logic        we_chi_s;
    logic        we_ctrl_s;
    logic        we_stat_s;
    logic        rd_mlo_s;
    logic        tick_s;
    logic        cmp_hit_s;
    logic        stat_clr_s;
    logic [31:0] ctrl_rd_s;
    logic [31:0] ctrl_wr_s;
    logic [31:0] rd_mux_s;

    // Address decode and per-register write strobes.
    always_comb begin
        off_s     = addr[7:0];
        hit_s     = cs & (addr[31:8] == BASE_HI) & (addr[1:0] == 2'b00);
        rd_hit_s  = hit_s & ~wr;
        wr_hit_s  = hit_s & wr;
        we_mlo_s  = wr_hit_s & (off_s == OFF_MLO);
        we_mhi_s  = wr_hit_s & (off_s == OFF_MHI);
        we_clo_s  = wr_hit_s & (off_s == OFF_CLO);
        we_chi_s  = wr_hit_s & (off_s == OFF_CHI);
        we_ctrl_s = wr_hit_s & (off_s == OFF_CTRL);
        we_stat_s = wr_hit_s & (off_s == OFF_STAT);
        rd_mlo_s  = rd_hit_s & (off_s == OFF_MLO);
        stat_clr_s = we_stat_s & mask[0] & data_wr[0];
    end

    // CTRL image as software sees it, and the byte-merged value of a CTRL write.
    always_comb begin
        ctrl_rd_s              = 32'd0;
        ctrl_rd_s[0]           = en_r;
        ctrl_rd_s[1]           = ie_r;
        ctrl_rd_s[8 +: PRESC_W] = div_r;
        ctrl_wr_s              = merge_bytes(ctrl_rd_s, data_wr, mask);
    end

    // Prescaler tick and unsigned 64-bit compare on registered values.
    always_comb begin
        tick_s    = en_r & (pcnt_r == div_r);
        cmp_hit_s = (mtime_r >= cmp_r);
    end

    // Combinational read mux; anything that is not a read hit returns 0.
    always_comb begin
        rd_mux_s = 32'd0;
        case (off_s)
            OFF_MLO:  rd_mux_s = mtime_r[31:0];
            OFF_MHI:  rd_mux_s = hi_shadow_r;
            OFF_CLO:  rd_mux_s = cmp_r[31:0];
            OFF_CHI:  rd_mux_s = cmp_r[63:32];
            OFF_CTRL: rd_mux_s = ctrl_rd_s;
            OFF_STAT: rd_mux_s = {31'd0, pending_r};
            default:  rd_mux_s = 32'd0;
        endcase
        if (rd_hit_s) begin
            data_rd = rd_mux_s;
        end else begin
            data_rd = 32'd0;
        end
    end

    // mtime next value: a software write wins over the tick in the same cycle.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (we_mlo_s) begin
            mtime_nxt_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], data_wr, mask)};
        end else if (we_mhi_s) begin
            mtime_nxt_s = {merge_bytes(mtime_r[63:32], data_wr, mask), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Prescale counter: restarts on any CTRL or mtime write so the new
    // setting always begins with a full divide period.
    always_comb begin
        pcnt_nxt_s = pcnt_r;
        if (we_ctrl_s | we_mlo_s | we_mhi_s) begin
            pcnt_nxt_s = {PRESC_W{1'b0}};
        end else if (tick_s) begin
            pcnt_nxt_s = {PRESC_W{1'b0}};
        end else if (en_r) begin
            pcnt_nxt_s = pcnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
        end else begin
            pcnt_nxt_s = pcnt_r;
        end
    end

    // Compare register next value (byte-masked per half).
    always_comb begin
        cmp_nxt_s = cmp_r;
        if (we_clo_s) begin
            cmp_nxt_s = {cmp_r[63:32], merge_bytes(cmp_r[31:0], data_wr, mask)};
        end else if (we_chi_s) begin
            cmp_nxt_s = {merge_bytes(cmp_r[63:32], data_wr, mask), cmp_r[31:0]};
        end else begin
            cmp_nxt_s = cmp_r;
        end
    end

    // Control fields next value.
    always_comb begin
        en_nxt_s  = en_r;
        ie_nxt_s  = ie_r;
        div_nxt_s = div_r;
        if (we_ctrl_s) begin
            en_nxt_s  = ctrl_wr_s[0];
            ie_nxt_s  = ctrl_wr_s[1];
            div_nxt_s = ctrl_wr_s[8 +: PRESC_W];
        end else begin
            en_nxt_s  = en_r;
            ie_nxt_s  = ie_r;
            div_nxt_s = div_r;
        end
    end

    // HI shadow captures the pre-tick upper half whenever LO is read, so a
    // following HI read pairs coherently with the LO value across a carry.
    always_comb begin
        hi_shadow_nxt_s = hi_shadow_r;
        if (rd_mlo_s) begin
            hi_shadow_nxt_s = mtime_r[63:32];
        end else begin
            hi_shadow_nxt_s = hi_shadow_r;
        end
    end

    // Pending flag: a live compare hit beats a software clear, so software
    // must move mtimecmp forward before acknowledging.
    always_comb begin
        pending_nxt_s = pending_r;
        if (cmp_hit_s) begin
            pending_nxt_s = 1'b1;
        end else if (stat_clr_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_r     <= 64'd0;
            cmp_r       <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_r        <= 1'b0;
            ie_r        <= 1'b0;
            div_r       <= {PRESC_W{1'b0}};
            pcnt_r      <= {PRESC_W{1'b0}};
            hi_shadow_r <= 32'd0;
            pending_r   <= 1'b0;
        end else begin
            mtime_r     <= mtime_nxt_s;
            cmp_r       <= cmp_nxt_s;
            en_r        <= en_nxt_s;
            ie_r        <= ie_nxt_s;
            div_r       <= div_nxt_s;
            pcnt_r      <= pcnt_nxt_s;
            hi_shadow_r <= hi_shadow_nxt_s;
            pending_r   <= pending_nxt_s;
        end
    end

    // Outputs: mtime is a register; ie gates the pending flag directly.
    always_comb begin
        mtime_o   = mtime_r;
        timer_irq = pending_r & ie_r;
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        timer_irq;
    logic [63:0] mtime_o;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    string       name_q[$];

    mmio_timer_responder #(
        .BASE_ADDR (BASE),
        .PRESC_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .wr        (wr),
        .mask      (mask),
        .addr      (addr),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .timer_irq (timer_irq),
        .mtime_o   (mtime_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        cs = 1'b1; wr = 1'b1; addr = a; data_wr = d; mask = m;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; mask = 4'h0; data_wr = 32'd0;
    endtask

    // Push the expectation, drive the read, then pop and compare.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] e;
        string n;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cs = 1'b1; wr = 1'b0; addr = a; mask = 4'h0; data_wr = 32'd0;
        #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (data_rd !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, data_rd, e);
        end
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic check_irq(input logic exp, input string nm);
        total++;
        if (timer_irq !== exp) begin
            bad++;
            $display("FAIL %s: timer_irq got %b expected %b", nm, timer_irq, exp);
        end
    endtask

    task automatic test_reset();
        total++;
        if (mtime_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_mtime_o: got %h expected 0", mtime_o);
        end
        check_irq(1'b0, "reset_irq");
        do_read(BASE + 32'h00, 32'h0000_0000, "reset_mtime_lo");
        do_read(BASE + 32'h04, 32'h0000_0000, "reset_mtime_hi");
        do_read(BASE + 32'h08, 32'hFFFF_FFFF, "reset_cmp_lo");
        do_read(BASE + 32'h0C, 32'hFFFF_FFFF, "reset_cmp_hi");
        do_read(BASE + 32'h10, 32'h0000_0000, "reset_ctrl");
        do_read(BASE + 32'h14, 32'h0000_0000, "reset_status");
        do_read(BASE + 32'h18, 32'h0000_0000, "reset_unmapped");
    endtask

    task automatic test_prescaler();
        bus_write(BASE + 32'h10, 32'h0000_0301, 4'hF);
        do_read(BASE + 32'h10, 32'h0000_0301, "ctrl_readback");
        // The readback consumed one cycle: 39 more gives 40 after the write.
        repeat (39) @(negedge clk);
        do_read(BASE + 32'h00, 32'd10, "presc_div3_40cyc");
        bus_write(BASE + 32'h10, 32'h0000_0000, 4'hF);
        repeat (8) @(negedge clk);
        do_read(BASE + 32'h00, 32'd10, "presc_hold_when_off");
    endtask

    task automatic test_wrap();
        bus_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        bus_write(BASE + 32'h04, 32'h0000_0000, 4'hF);
        bus_write(BASE + 32'h10, 32'h0000_0001, 4'hF);
        do_read(BASE + 32'h00, 32'hFFFF_FFFF, "wrap_lo");
        @(negedge clk);
        do_read(BASE + 32'h04, 32'h0000_0000, "wrap_hi_coherent");
        do_read(BASE + 32'h04, 32'h0000_0000, "wrap_hi_stale");
        total++;
        if (mtime_o[63:32] !== 32'd1) begin
            bad++;
            $display("FAIL wrap_mtime_o_hi: got %h expected 1", mtime_o[63:32]);
        end
        cs = 1'b1; wr = 1'b0; addr = BASE; #1;
        @(negedge clk);
        cs = 1'b0;
        do_read(BASE + 32'h04, 32'h0000_0001, "wrap_hi_after_carry");
        bus_write(BASE + 32'h10, 32'h0000_0000, 4'hF);
    endtask

    task automatic test_compare();
        int cnt;
        bus_write(BASE + 32'h00, 32'd0, 4'hF);
        bus_write(BASE + 32'h04, 32'd0, 4'hF);
        bus_write(BASE + 32'h08, 32'd20, 4'hF);
        bus_write(BASE + 32'h0C, 32'd0, 4'hF);
        check_irq(1'b0, "cmp_idle_irq");
        bus_write(BASE + 32'h10, 32'h0000_0003, 4'hF);
        cnt = 0;
        while (mtime_o != 64'd20 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        total++;
        if (cnt !== 20) begin
            bad++;
            $display("FAIL cmp_reach_20: cycles got %0d expected 20", cnt);
        end
        check_irq(1'b0, "cmp_irq_at_equal");
        @(negedge clk);
        check_irq(1'b1, "cmp_irq_one_after");
        bus_write(BASE + 32'h14, 32'h0000_0001, 4'h1);
        check_irq(1'b1, "cmp_clear_loses");
        do_read(BASE + 32'h14, 32'h0000_0001, "cmp_status_set");
        bus_write(BASE + 32'h10, 32'h0000_0001, 4'hF);
        check_irq(1'b0, "cmp_ie_gate");
        do_read(BASE + 32'h14, 32'h0000_0001, "cmp_status_gated");
        bus_write(BASE + 32'h10, 32'h0000_0003, 4'hF);
        check_irq(1'b1, "cmp_ie_reenable");
        bus_write(BASE + 32'h0C, 32'h0000_0001, 4'hF);
        check_irq(1'b1, "cmp_raised_still_pending");
        bus_write(BASE + 32'h14, 32'h0000_0001, 4'h1);
        check_irq(1'b0, "cmp_cleared");
        do_read(BASE + 32'h14, 32'h0000_0000, "cmp_status_clear");
        bus_write(BASE + 32'h10, 32'h0000_0000, 4'hF);
    endtask

    task automatic test_byte_mask();
        bus_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
        bus_write(BASE + 32'h08, 32'hAABB_CCDD, 4'b0101);
        do_read(BASE + 32'h08, 32'hFFBB_FFDD, "mask_cmp_lo");
        do_read(BASE + 32'h0C, 32'h0000_0001, "mask_cmp_hi");
    endtask

    task automatic test_invalid();
        bus_write(BASE + 32'h0A, 32'h0000_0000, 4'hF);
        bus_write(32'h0000_3008, 32'h0000_0000, 4'hF);
        bus_write(BASE + 32'h18, 32'h1234_5678, 4'hF);
        do_read(BASE + 32'h08, 32'hFFBB_FFDD, "inv_cmp_unchanged");
        do_read(BASE + 32'h02, 32'h0000_0000, "inv_misaligned_rd");
        do_read(32'h0000_3008, 32'h0000_0000, "inv_window_rd");
        do_read(BASE + 32'h18, 32'h0000_0000, "inv_unmapped_rd");
        cs = 1'b0; wr = 1'b0; addr = BASE + 32'h08; #1;
        total++;
        if (data_rd !== 32'd0) begin
            bad++;
            $display("FAIL inv_no_cs: got %h expected 0", data_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus_write(BASE + 32'h08, 32'h1234_5678, 4'hF);
        do_read(BASE + 32'h08, 32'h1234_5678, "b2b_cmp_lo");
        bus_write(BASE + 32'h0C, 32'h9ABC_DEF0, 4'hF);
        do_read(BASE + 32'h0C, 32'h9ABC_DEF0, "b2b_cmp_hi");
        bus_write(BASE + 32'h10, 32'h0000_0A02, 4'hF);
        do_read(BASE + 32'h10, 32'h0000_0A02, "b2b_ctrl");
        bus_write(BASE + 32'h10, 32'h0000_0000, 4'hF);
    endtask

    task automatic test_async_reset();
        bus_write(BASE + 32'h00, 32'd0, 4'hF);
        bus_write(BASE + 32'h04, 32'd0, 4'hF);
        bus_write(BASE + 32'h08, 32'd5, 4'hF);
        bus_write(BASE + 32'h0C, 32'd0, 4'hF);
        bus_write(BASE + 32'h10, 32'h0000_0003, 4'hF);
        repeat (10) @(negedge clk);
        check_irq(1'b1, "arst_irq_before");
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (mtime_o !== 64'd0) begin
            bad++;
            $display("FAIL arst_mtime_o: got %h expected 0", mtime_o);
        end
        check_irq(1'b0, "arst_irq_async");
        @(negedge clk);
        do_read(BASE + 32'h08, 32'hFFFF_FFFF, "arst_cmp_lo");
        do_read(BASE + 32'h10, 32'h0000_0000, "arst_ctrl");
        do_read(BASE + 32'h14, 32'h0000_0000, "arst_status");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        do_read(BASE + 32'h00, 32'h0000_0000, "arst_mtime_held");
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        cs = 1'b0;
        wr = 1'b0;
        mask = 4'h0;
        addr = 32'd0;
        data_wr = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_prescaler();
        test_wrap();
        test_compare();
        test_byte_mask();
        test_invalid();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
- Memory-mapped machine-timer peripheral. It responds to the load/store unit's data-memory request interface (cs, wr, mask, addr, data_wr), alongside the data memory, and returns data_rd.
- Holds a 64-bit free-running mtime counter with a programmable prescaler, a 64-bit mtimecmp compare register, and control/status registers.
- Drives a level timer interrupt toward the core's future trap logic.
- Reads are combinational (same cycle as the MEM-stage request); writes commit on the rising clock edge.

Parameters:
- BASE_ADDR, 32'h0000_2000, base of the 256-byte register window; addr[31:8] must equal BASE_ADDR[31:8].
- PRESC_W, 8, width of the prescaler divide field and counter.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-low reset
- cs  input  1  request select, active-high, from the LSU
- wr  input  1  1 = write, 0 = read; qualified by cs
- mask  input  4  byte enables for writes; bit n enables data_wr[8n+7:8n]
- addr  input  32  byte address from the LSU
- data_wr  input  32  write data
- data_rd  output  32  read data; combinational
- timer_irq  output  1  level interrupt = irq_pending & CTRL.ie
- mtime_o  output  64  current mtime, for debug/CSR shadowing

Behaviour:
- Hit = cs & (addr[31:8]==BASE_ADDR[31:8]) & (addr[1:0]==0).
  - Misaligned or out-of-window accesses are not hits: writes are ignored and data_rd=0.
- Register map, offset addr[7:0]:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI (read returns the HI shadow)
  - 0x08 CMP_LO
  - 0x0C CMP_HI
  - 0x10 CTRL: bit0 en, bit1 ie, bits[8+PRESC_W-1:8] div
  - 0x14 STATUS: bit0 irq_pending, write-1-to-clear
  - Other offsets read 0 and ignore writes.
- Reset (rst=0, asynchronous):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescale counter=0, HI shadow=0, irq_pending=0.
  - Outputs: timer_irq=0, mtime_o=0. data_rd follows its decode (0 when no hit).
- Prescaler:
  - When en=1, pcnt increments each cycle.
  - When pcnt==div: pcnt returns to 0 and mtime increments by 1.
  - Net effect: mtime ticks every div+1 cycles; div=0 means every cycle.
  - When en=0, pcnt and mtime hold. Writing CTRL clears pcnt.
- mtime is 64-bit and wraps from all-ones to 0 silently.
- Software write to MTIME_LO or MTIME_HI:
  - Byte-masked write to that half only.
  - Overrides the tick increment in the same cycle (write wins, no increment that cycle).
  - Clears pcnt.
- Read of MTIME_LO:
  - data_rd = mtime[31:0].
  - At the clock edge, the HI shadow captures mtime[63:32] as of that cycle, so a subsequent HI read is coherent even across a carry.
  - A HI read without a prior LO read returns the stale shadow.
- CMP_LO and CMP_HI: byte-masked writes, read back directly.
- Compare: cmp_hit = (mtime >= mtimecmp), unsigned 64-bit, evaluated on registered values every cycle.
  - When cmp_hit=1, irq_pending is set at the next edge.
- STATUS write with data_wr[0]=1 and mask[0]=1 clears irq_pending.
  - If cmp_hit is 1 in the same cycle, set wins and pending remains 1.
  - Software must raise mtimecmp before clearing.
- Latency:
  - Register writes are visible to reads on the next cycle.
  - timer_irq asserts 1 cycle after mtime first reaches mtimecmp, provided ie=1.
  - ie gates timer_irq combinationally.
- A read and a tick in the same cycle return the pre-increment value.

Test Plan:
- Reset, then read every offset -> MTIME 0/0, CMP_LO=CMP_HI=32'hFFFF_FFFF, CTRL=0, STATUS=0, timer_irq=0.
- Write CTRL=32'h0000_0301 (en=1, div=3), idle 40 cycles, read MTIME_LO -> 10; mtime ticks every 4 cycles.
- Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, div=0, en=1. Read LO, then HI two cycles later:
  - LO = FFFF_FFFF or wrapped value; HI shadow is consistent with it (0 with LO FFFF_FFFF, or 1 with the wrapped low value).
- CMP=64'd20, CTRL en=1 ie=1 div=0 from mtime=0:
  - irq_pending and timer_irq rise 1 cycle after mtime==20.
  - Writing STATUS=1 keeps them high while mtime≥cmp.
  - Writing CMP_HI=1, then STATUS=1, drops timer_irq next cycle.
- Byte-masked write: CMP_LO=32'hAABBCCDD with mask=4'b0101 over 32'hFFFF_FFFF -> read 32'hFFBBFFDD.
- Misaligned/out-of-window/reset cases:
  - Write at BASE+0x02 or 0x0000_3000 -> no register change, data_rd=0.
  - Assert rst mid-count -> all state returns to reset values immediately, asynchronously.
